wb_arbiter: RTL and testbench

- Sole driver of the register-file write port (reg_write/rd/wd); the producer side of the regfile write interface.
- Merges single-cycle ALU/load results with buffered multiply/divide results and emits at most one write per cycle.
- Keeps a busy scoreboard of destination registers with outstanding mul/div ops so decode can stall on RAW hazards.

---
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges single-cycle ALU results with queued
// mul/div results and tracks destinations that still have a mul/div in flight.
module wb_arbiter #(
  parameter int unsigned MD_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        alu_stall,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] wd,
  output logic [31:0] busy_mask,
  output logic        err
);

  localparam int unsigned AW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int unsigned CW = $clog2(MD_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd   [MD_DEPTH];
  logic [31:0]   fifo_data [MD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          fifo_nonempty, push, pop, starve_inc, err_now;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [31:0]   busy_set, busy_clr, busy_next;

  assign md_ready      = (count != CW'(MD_DEPTH));
  assign fifo_nonempty = (count != '0);
  assign push          = md_valid && md_ready;
  // Head is only eligible when the ALU path is idle; a same-cycle push never bypasses.
  assign pop           = !alu_valid && fifo_nonempty;
  assign starve_inc    = alu_valid && fifo_nonempty;
  assign head_rd       = fifo_rd[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (md_issue && (md_issue_rd != '0))
      busy_set = 32'(1) << md_issue_rd;
    if (pop && (head_rd != '0))
      busy_clr = 32'(1) << head_rd;
    busy_next = (busy_mask & ~busy_clr) | busy_set;
  end

  always_comb begin
    err_now = 1'b0;
    if (alu_valid && alu_stall)
      err_now = 1'b1;
    if (md_issue && (md_issue_rd != '0) && busy_mask[md_issue_rd] && !busy_clr[md_issue_rd])
      err_now = 1'b1;
    if (push && !busy_mask[md_rd])
      err_now = 1'b1;
  end

  // Storage needs no reset: occupancy is governed entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= md_rd;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      reg_write  <= 1'b0;
      rd         <= '0;
      wd         <= '0;
      busy_mask  <= '0;
      err        <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);

      alu_stall <= 1'b0;
      if (pop) begin
        starve_cnt <= '0;
      end else if (starve_inc) begin
        if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
          starve_cnt <= '0;
          alu_stall  <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end

      if (alu_valid) begin
        reg_write <= (alu_rd != '0);
        rd        <= alu_rd;
        wd        <= alu_data;
      end else if (pop) begin
        reg_write <= (head_rd != '0);
        rd        <= head_rd;
        wd        <= head_data;
      end else begin
        reg_write <= 1'b0;
      end

      busy_mask <= busy_next;
      if (err_now)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked against
// a queue-based reference model of the write-back rules.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        alu_stall, reg_write, err;
  logic [4:0]  rd;
  logic [31:0] wd, busy_mask;

  wb_arbiter #(.MD_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .alu_stall(alu_stall), .reg_write(reg_write), .rd(rd), .wd(wd),
    .busy_mask(busy_mask), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          q_rd[$];
  logic [31:0] q_data[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_stall, m_err;
  bit          e_sel, e_rw;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  int          issued[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    issued.delete();
    m_busy = '0; m_starve = 0; m_stall = 0; m_err = 0; e_rw = 0; e_sel = 0;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    md_issue = 0; md_issue_rd = '0; md_valid = 0; md_rd = '0; md_data = '0;
  endtask

  // Apply the inputs currently driven for one clock and compare every output.
  task automatic step();
    bit push, pop, fifo_had;
    logic [31:0] clr, set;
    fifo_had = (q_rd.size() > 0);
    push = md_valid && (q_rd.size() < DEPTH);
    pop  = !alu_valid && fifo_had;
    clr = '0; set = '0;
    if (pop && q_rd[0] != 0) clr[q_rd[0]] = 1'b1;
    if (md_issue && md_issue_rd != 0) set[md_issue_rd] = 1'b1;
    if (alu_valid && m_stall) m_err = 1;
    if (md_issue && md_issue_rd != 0 && m_busy[md_issue_rd] && !clr[md_issue_rd]) m_err = 1;
    if (push && !m_busy[md_rd]) m_err = 1;
    e_sel = alu_valid || pop;
    if (alu_valid) begin
      e_rw = (alu_rd != 0); e_rd = alu_rd; e_wd = alu_data;
    end else if (pop) begin
      e_rw = (q_rd[0] != 0); e_rd = 5'(q_rd[0]); e_wd = q_data[0];
    end else begin
      e_rw = 0;
    end
    m_stall = 0;
    if (pop) m_starve = 0;
    else if (alu_valid && fifo_had) begin
      m_starve++;
      if (m_starve == LIMIT) begin m_starve = 0; m_stall = 1; end
    end
    m_busy = (m_busy & ~clr) | set;
    if (pop) begin void'(q_rd.pop_front()); void'(q_data.pop_front()); end
    if (push) begin q_rd.push_back(int'(md_rd)); q_data.push_back(md_data); end
    @(posedge clk); #1;
    check("reg_write", 32'(reg_write), 32'(e_rw));
    if (e_sel) begin
      check("rd", 32'(rd), 32'(e_rd));
      check("wd", wd, e_wd);
    end
    check("alu_stall", 32'(alu_stall), 32'(m_stall));
    check("busy_mask", busy_mask, m_busy);
    check("err", 32'(err), 32'(m_err));
    check("md_ready", 32'(md_ready), 32'(q_rd.size() < DEPTH));
    clear_inputs();
  endtask

  task automatic issue(input logic [4:0] r);
    md_issue = 1; md_issue_rd = r; step();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_reg_write", 32'(reg_write), 32'h0);
    check("rst_busy", busy_mask, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_stall", 32'(alu_stall), 32'h0);
    @(posedge clk); #1 rst_n = 1;
    check("rst_md_ready", 32'(md_ready), 32'h1);

    // Single ALU write, visible one cycle later, then idle.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h64; step();
    check("alu_wd", wd, 32'h0000_0064);
    step();
    check("alu_idle", 32'(reg_write), 32'h0);

    // Mul/div path: issue x5, push, written two cycles after the push.
    issue(5'd5);
    check("busy_x5", busy_mask, 32'h20);
    md_valid = 1; md_rd = 5'd5; md_data = 32'hDEAD; step();
    step();
    check("md_rd5", 32'(rd), 32'd5);
    check("md_busy_clr", busy_mask, 32'h0);

    // Starvation: fill FIFO while ALU stays busy.
    issue(5'd6); issue(5'd7); issue(5'd8);
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1; md_valid = 1; md_rd = 5'd6; md_data = 32'h66; step();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h2; md_valid = 1; md_rd = 5'd7; md_data = 32'h77; step();
    check("full_ready", 32'(md_ready), 32'h0);
    for (int i = 0; i < 10 && !m_stall; i++) begin
      alu_valid = 1; alu_rd = 5'd2; alu_data = 32'(i); step();
    end
    check("stall_seen", 32'(alu_stall), 32'h1);
    step();
    check("stall_head_rd", 32'(rd), 32'd6);
    check("stall_ready", 32'(md_ready), 32'h1);

    // Push and pop in the same cycle with one entry queued.
    md_valid = 1; md_rd = 5'd8; md_data = 32'h88; step();
    check("pp_rd7", 32'(rd), 32'd7);
    step();
    check("pp_rd8", 32'(rd), 32'd8);
    check("pp_wd8", wd, 32'h88);

    // Random traffic; the stimulus respects every protocol rule, so err stays 0.
    for (int c = 0; c < 400; c++) begin
      if (!m_stall && ($urandom_range(3, 0) != 0)) begin
        alu_valid = 1; alu_rd = 5'($urandom_range(31, 0)); alu_data = $urandom;
      end
      if ($urandom_range(2, 0) == 0) begin
        int r;
        r = $urandom_range(31, 1);
        if (!m_busy[r]) begin
          md_issue = 1; md_issue_rd = 5'(r);
        end
      end
      if (issued.size() > 0 && q_rd.size() < DEPTH && $urandom_range(1, 0) == 1) begin
        md_valid = 1; md_rd = 5'(issued.pop_front()); md_data = $urandom;
      end
      if (md_issue) issued.push_back(int'(md_issue_rd));
      step();
    end
    for (int i = 0; i < 8; i++) begin
      if (issued.size() > 0 && q_rd.size() < DEPTH) begin
        md_valid = 1; md_rd = 5'(issued.pop_front()); md_data = $urandom;
      end
      step();
    end
    check("rand_err", 32'(err), 32'h0);

    // x0 writes, then protocol error on re-issuing a busy register.
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55; step();
    check("x0_alu", 32'(reg_write), 32'h0);
    issue(5'd5);
    issue(5'd5);
    check("err_set", 32'(err), 32'h1);
    md_valid = 1; md_rd = 5'd5; md_data = 32'h5; step();
    step();
    md_valid = 1; md_rd = 5'd0; md_data = 32'h99; step();
    step();
    check("x0_md", 32'(reg_write), 32'h0);
    check("err_sticky", 32'(err), 32'h1);

    // Reset with two entries queued and x3/x5 busy.
    issue(5'd3); issue(5'd5);
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11; md_valid = 1; md_rd = 5'd3; md_data = 32'h33; step();
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h22; md_valid = 1; md_rd = 5'd5; md_data = 32'h55; step();
    check("pre_rst_busy", busy_mask, 32'h28);
    #2 rst_n = 0;
    #1;
    check("mid_rst_rw", 32'(reg_write), 32'h0);
    check("mid_rst_rd", 32'(rd), 32'h0);
    check("mid_rst_wd", wd, 32'h0);
    check("mid_rst_busy", busy_mask, 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) step();
    check("post_rst_rw", 32'(reg_write), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
